// File: rtl/control_cmd_dumpframe.sv
// control_cmd_dumpframe: walks the frame buffer and streams each RAM byte to the transmitter
//   clk, reset (async, active-low)     : clock and reset
//   start, abort                        : begin a dump / cancel it
//   row, column, pixel, ram_read_enable : RAM read address and one-cycle read strobe
//   ram_data_in                         : RAM read data, valid RAM_READ_LATENCY cycles after the strobe
//   tx_data, tx_valid, tx_ready         : byte handshake towards the UART transmitter
//   busy, done                          : dump in progress / one-cycle completion pulse
module control_cmd_dumpframe #(
    parameter int PIXEL_HEIGHT     = 32,
    parameter int PIXEL_WIDTH      = 64,
    parameter int BYTES_PER_PIXEL  = 2,
    parameter int RAM_READ_LATENCY = 1,
    localparam int _NUM_ROW_ADDRESS_BITS      = PIXEL_HEIGHT    > 1 ? $clog2(PIXEL_HEIGHT)    : 1,
    localparam int _NUM_COLUMN_ADDRESS_BITS   = PIXEL_WIDTH     > 1 ? $clog2(PIXEL_WIDTH)     : 1,
    localparam int _NUM_PIXELCOLORSELECT_BITS = BYTES_PER_PIXEL > 1 ? $clog2(BYTES_PER_PIXEL) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  abort,
    output logic [_NUM_ROW_ADDRESS_BITS-1:0]      row,
    output logic [_NUM_COLUMN_ADDRESS_BITS-1:0]   column,
    output logic [_NUM_PIXELCOLORSELECT_BITS-1:0] pixel,
    output logic                                  ram_read_enable,
    input  logic [7:0]                            ram_data_in,
    output logic [7:0]                            tx_data,
    output logic                                  tx_valid,
    input  logic                                  tx_ready,
    output logic                                  busy,
    output logic                                  done
);
    localparam int RW = _NUM_ROW_ADDRESS_BITS;
    localparam int CW = _NUM_COLUMN_ADDRESS_BITS;
    localparam int PW = _NUM_PIXELCOLORSELECT_BITS;
    localparam logic [RW-1:0] row_top = RW'(PIXEL_HEIGHT - 1);
    localparam logic [CW-1:0] col_top = CW'(PIXEL_WIDTH - 1);
    localparam logic [PW-1:0] pix_top = PW'(BYTES_PER_PIXEL - 1);
    localparam logic [1:0]    cnt_load = 2'(RAM_READ_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, DONE} state_t;

    state_t        state, state_n;
    logic [RW-1:0] row_n;
    logic [CW-1:0] column_n;
    logic [PW-1:0] pixel_n;
    logic [1:0]    cnt, cnt_n;
    logic [7:0]    tx_data_n;
    logic          last;

    // All handshake/status outputs decode straight from the state register,
    // so nothing combinational reaches them from ram_data_in or tx_ready.
    assign ram_read_enable = state == ISSUE;
    assign tx_valid        = state == PRESENT;
    assign done            = state == DONE;
    assign busy            = state != IDLE;
    assign last            = row == '0 && column == '0 && pixel == '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            row     <= '0;
            column  <= '0;
            pixel   <= '0;
            cnt     <= '0;
            tx_data <= '0;
        end else begin
            state   <= state_n;
            row     <= row_n;
            column  <= column_n;
            pixel   <= pixel_n;
            cnt     <= cnt_n;
            tx_data <= tx_data_n;
        end
    end

    always_comb begin
        state_n   = state;
        row_n     = row;
        column_n  = column;
        pixel_n   = pixel;
        cnt_n     = cnt;
        tx_data_n = tx_data;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_n  = ISSUE;
                    row_n    = row_top;
                    column_n = col_top;
                    pixel_n  = pix_top;
                end
                ISSUE: begin
                    cnt_n   = cnt_load;
                    state_n = WAIT;
                end
                WAIT: if (cnt == '0) begin
                    tx_data_n = ram_data_in;
                    state_n   = PRESENT;
                end else begin
                    cnt_n = cnt - 2'd1;
                end
                PRESENT: if (tx_ready) begin
                    // Terminal check comes first so no address ever wraps below zero.
                    if (last) begin
                        state_n = DONE;
                    end else begin
                        state_n = ISSUE;
                        if (pixel != '0) begin
                            pixel_n = pixel - PW'(1);
                        end else begin
                            pixel_n = pix_top;
                            if (column != '0) begin
                                column_n = column - CW'(1);
                            end else begin
                                column_n = col_top;
                                row_n    = row - RW'(1);
                            end
                        end
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_control_cmd_dumpframe.sv
// tb_control_cmd_dumpframe: directed checks of the frame dump on a 2x2x2 frame at latencies 1 and 3
module tb_control_cmd_dumpframe;
    logic clk = 0, reset = 0, start = 0, start3 = 0, abort = 0, tx_ready = 1;
    logic row1, col1, pix1, re1, v1, busy1, done1;
    logic row3, col3, pix3, re3, v3, busy3, done3;
    logic [7:0] rd1, td1, rd3, td3;
    logic [8:0] pipe1;
    logic [8:0] pipe3 [3];
    int cyc = 0, done1_cnt = 0, done1_cyc = 0, done3_cnt = 0;
    int errors = 0, checks = 0;
    logic [7:0] q1[$], q3[$];
    int c1q[$], r1q[$], c3q[$], r3q[$];

    always #5 clk = ~clk;

    control_cmd_dumpframe #(.PIXEL_HEIGHT(2), .PIXEL_WIDTH(2), .BYTES_PER_PIXEL(2), .RAM_READ_LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .row(row1), .column(col1), .pixel(pix1), .ram_read_enable(re1), .ram_data_in(rd1),
        .tx_data(td1), .tx_valid(v1), .tx_ready(tx_ready), .busy(busy1), .done(done1));

    control_cmd_dumpframe #(.PIXEL_HEIGHT(2), .PIXEL_WIDTH(2), .BYTES_PER_PIXEL(2), .RAM_READ_LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .start(start3), .abort(abort),
        .row(row3), .column(col3), .pixel(pix3), .ram_read_enable(re3), .ram_data_in(rd3),
        .tx_data(td3), .tx_valid(v3), .tx_ready(tx_ready), .busy(busy3), .done(done3));

    // RAM model: data 0xA0|{row,col,pix} appears only in the exact cycle L after the strobe, 0xEE otherwise.
    always @(posedge clk) begin
        pipe1    <= {re1, 5'b10100, row1, col1, pix1};
        pipe3[0] <= {re3, 5'b10100, row3, col3, pix3};
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign rd1 = pipe1[8] ? pipe1[7:0] : 8'hEE;
    assign rd3 = pipe3[2][8] ? pipe3[2][7:0] : 8'hEE;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (v1 && tx_ready) begin q1.push_back(td1); c1q.push_back(cyc); end
        if (re1) r1q.push_back(cyc);
        if (done1) begin done1_cnt <= done1_cnt + 1; done1_cyc <= cyc; end
        if (v3 && tx_ready) begin q3.push_back(td3); c3q.push_back(cyc); end
        if (re3) r3q.push_back(cyc);
        if (done3) done3_cnt <= done3_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full dump on u1 with optional 5-cycle stall on byte index stall_at and a start pulse at restart_at.
    task automatic dump1(input int stall_at, input int restart_at);
        int qb, rb, db;
        bit ok = 0, stalled = 0, restarted = 0;
        qb = q1.size(); rb = r1q.size(); db = done1_cnt;
        start = 1; @(negedge clk); start = 0;
        chk("busy_after_start", busy1, 1);
        chk("issue_strobe", re1, 1);
        chk("first_addr", {row1, col1, pix1}, 3'b111);
        for (int i = 0; i < 300 && !ok; i++) begin
            if (stall_at >= 0 && !stalled && q1.size() - qb == stall_at && v1) begin
                stalled = 1; tx_ready = 0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_valid", v1, 1);
                    chk("stall_data", td1, 8'hA0 | 8'(7 - stall_at));
                    chk("stall_reads", r1q.size() - rb, stall_at + 1);
                end
                tx_ready = 1;
            end
            if (restart_at >= 0 && !restarted && q1.size() - qb == restart_at) begin
                restarted = 1; start = 1; @(negedge clk); start = 0;
                chk("restart_ignored_busy", busy1, 1);
            end
            if (done1) ok = 1; else @(negedge clk);
        end
        chk("dump_timeout", ok, 1);
        chk("done_addr_zero", {row1, col1, pix1}, 0);
        @(negedge clk);
        chk("done_one_cycle", done1, 0);
        chk("busy_cleared", busy1, 0);
        chk("byte_count", q1.size() - qb, 8);
        chk("read_count", r1q.size() - rb, 8);
        chk("done_count", done1_cnt - db, 1);
        chk("done_after_last", done1_cyc - c1q[qb + 7], 1);
        for (int k = 0; k < 8; k++) begin
            chk("byte_data", q1[qb + k], 8'hA0 | 8'(7 - k));
            chk("read_to_handshake", c1q[qb + k] - r1q[rb + k], k == stall_at ? 7 : 2);
            if (k > 0) chk("byte_interval", c1q[qb + k] - c1q[qb + k - 1], k == stall_at ? 8 : 3);
        end
    endtask

    initial begin
        int qb, rb, db;
        bit ok;
        @(negedge clk);
        chk("rst_addr", {row1, col1, pix1}, 0);
        chk("rst_tx_data", td1, 0);
        chk("rst_strobes", {re1, v1, busy1, done1}, 0);
        reset = 1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy1, 0);

        dump1(-1, -1);
        dump1(2, -1);
        dump1(-1, 3);

        // Latency 3 on u3
        qb = q3.size(); rb = r3q.size(); ok = 0;
        start3 = 1; @(negedge clk); start3 = 0;
        for (int i = 0; i < 300 && !ok; i++) if (done3) ok = 1; else @(negedge clk);
        chk("l3_timeout", ok, 1);
        @(negedge clk);
        chk("l3_busy_cleared", busy3, 0);
        chk("l3_done_count", done3_cnt, 1);
        chk("l3_byte_count", q3.size() - qb, 8);
        for (int k = 0; k < 8; k++) begin
            chk("l3_byte_data", q3[qb + k], 8'hA0 | 8'(7 - k));
            chk("l3_read_to_handshake", c3q[qb + k] - r3q[rb + k], 4);
            if (k > 0) chk("l3_byte_interval", c3q[qb + k] - c3q[qb + k - 1], 5);
        end

        // abort and start together in IDLE: abort wins
        abort = 1; start = 1; @(negedge clk); abort = 0; start = 0;
        chk("abort_beats_start_busy", busy1, 0);
        chk("abort_beats_start_read", re1, 0);

        // abort while byte 5 is presented
        qb = q1.size(); rb = r1q.size(); db = done1_cnt; ok = 0;
        start = 1; @(negedge clk); start = 0;
        for (int i = 0; i < 300 && !ok; i++) if (q1.size() - qb == 4 && v1) ok = 1; else @(negedge clk);
        chk("abort_reach_byte5", ok, 1);
        tx_ready = 0; abort = 1; @(negedge clk); abort = 0; tx_ready = 1;
        chk("abort_busy", busy1, 0);
        chk("abort_valid", v1, 0);
        chk("abort_done", done1, 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", done1_cnt - db, 0);
        chk("abort_no_reads", r1q.size() - rb, 5);
        chk("abort_bytes", q1.size() - qb, 4);
        dump1(-1, -1);

        // async reset in WAIT of byte 3
        rb = r1q.size(); ok = 0;
        start = 1; @(negedge clk); start = 0;
        for (int i = 0; i < 300 && !ok; i++) if (r1q.size() - rb == 3) ok = 1; else @(negedge clk);
        chk("reset_reach_wait", ok, 1);
        #2 reset = 0;
        #1;
        chk("async_rst_addr", {row1, col1, pix1}, 0);
        chk("async_rst_tx_data", td1, 0);
        chk("async_rst_strobes", {re1, v1, busy1, done1}, 0);
        @(negedge clk); reset = 1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {busy1, re1}, 0);
        dump1(-1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
